audio_reverse_player: RTL and testbench

//  Stereo chunked reverse-playback effect: the reader end of a sample delay line.

---
 rtl/audio_reverse_player_if.sv | 27 ++
 rtl/audio_reverse_player.sv | 144 ++++++++++++++
 tb/tb_audio_reverse_player.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/audio_reverse_player_if.sv
// Sample bus between the codec deserializer side and the reverse player.
//   ready/enable/dry_mix, l_audio_in/r_audio_in : driven by the source (master)
//   l_audio_out/r_audio_out/out_valid/bank/playing : driven by the player (slave)
interface audio_reverse_player_if #(
  parameter int DATA_W = 18
);
  logic                     ready;
  logic                     enable;
  logic                     dry_mix;
  logic signed [DATA_W-1:0] l_audio_in;
  logic signed [DATA_W-1:0] r_audio_in;
  logic signed [DATA_W-1:0] l_audio_out;
  logic signed [DATA_W-1:0] r_audio_out;
  logic                     out_valid;
  logic                     bank;
  logic                     playing;

  modport master (
    output ready, enable, dry_mix, l_audio_in, r_audio_in,
    input  l_audio_out, r_audio_out, out_valid, bank, playing
  );

  modport slave (
    input  ready, enable, dry_mix, l_audio_in, r_audio_in,
    output l_audio_out, r_audio_out, out_valid, bank, playing
  );
endinterface

// File: rtl/audio_reverse_player.sv
// Stereo chunked reverse-playback effect.
// Samples are recorded forward into one bank of a ping-pong RAM while the other
// bank is played back last-sample-first. Outputs appear two clocks after ready.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : ready strobe, enable, dry_mix, stereo in/out samples,
//                  out_valid pulse, current write bank, playing flag
module audio_reverse_player #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13
) (
  input  logic                    clock,
  input  logic                    reset,
  audio_reverse_player_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FILL, PLAY} state_t;
  typedef enum logic [1:0] {M_BYPASS, M_FILL, M_PLAY} mode_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic                bank, bank_n;
  logic                wr_en, rd_en;
  mode_t               mode;

  logic [2*DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];
  logic [2*DATA_W-1:0] rd_data;
  logic [ADDR_W:0]     wr_addr, rd_addr;

  // Stage 1 (T+1) pipeline registers
  logic                     v1;
  mode_t                    mode1;
  logic                     mix1;
  logic signed [DATA_W-1:0] l_dry1, r_dry1;

  logic signed [DATA_W-1:0] l_wet, r_wet, l_res, r_res;

  // Next-state: only ready cycles advance; the first enabled sample seen in
  // IDLE is already recorded at ptr 0 and counts as a fill sample.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    bank_n  = bank;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    mode    = M_BYPASS;
    if (bus.ready && !reset) begin
      if (!bus.enable) begin
        state_n = IDLE;
        ptr_n   = '0;
        bank_n  = 1'b0;
      end else begin
        wr_en = 1'b1;
        rd_en = (state == PLAY);
        mode  = (state == PLAY) ? M_PLAY : M_FILL;
        ptr_n = ptr + 1'b1;
        if (state == IDLE) begin
          state_n = FILL;
        end else if (ptr == '1) begin
          bank_n  = ~bank;
          state_n = PLAY;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      bank  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      bank  <= bank_n;
    end
  end

  // (2^ADDR_W-1)-ptr is simply the bitwise inverse of ptr.
  assign wr_addr = {bank, ptr};
  assign rd_addr = {~bank, ~ptr};

  // RAM is deliberately not reset; the fill phase hides stale contents.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= {bus.l_audio_in, bus.r_audio_in};
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1     <= 1'b0;
      mode1  <= M_BYPASS;
      mix1   <= 1'b0;
      l_dry1 <= '0;
      r_dry1 <= '0;
    end else begin
      v1 <= bus.ready;
      if (bus.ready) begin
        mode1  <= mode;
        mix1   <= bus.dry_mix;
        l_dry1 <= bus.l_audio_in;
        r_dry1 <= bus.r_audio_in;
      end
    end
  end

  always_comb begin
    l_wet = '0;
    r_wet = '0;
    if (mode1 == M_PLAY) begin
      l_wet = rd_data[2*DATA_W-1:DATA_W];
      r_wet = rd_data[DATA_W-1:0];
    end
    l_res = l_dry1;
    r_res = r_dry1;
    if (mode1 != M_BYPASS) begin
      if (mix1) begin
        l_res = (l_wet >>> 1) + (l_dry1 >>> 1);
        r_res = (r_wet >>> 1) + (r_dry1 >>> 1);
      end else begin
        l_res = l_wet;
        r_res = r_wet;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.l_audio_out <= '0;
      bus.r_audio_out <= '0;
      bus.out_valid   <= 1'b0;
    end else begin
      bus.out_valid <= v1;
      if (v1) begin
        bus.l_audio_out <= l_res;
        bus.r_audio_out <= r_res;
      end
    end
  end

  assign bus.bank    = bank;
  assign bus.playing = (state == PLAY);

endmodule

// File: tb/tb_audio_reverse_player.sv
module tb_audio_reverse_player;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  audio_reverse_player_if #(.DATA_W(DATA_W)) bus ();

  audio_reverse_player #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sample: ready in cycle T, returns in cycle T+2 with out_valid checked.
  task automatic send(input logic signed [DATA_W-1:0] l,
                      input logic signed [DATA_W-1:0] r, input string tag);
    @(posedge clock); #1;
    bus.ready = 1'b1; bus.l_audio_in = l; bus.r_audio_in = r;
    @(posedge clock); #1;
    bus.ready = 1'b0;
    chk({tag, "_valid_t1"}, {31'd0, bus.out_valid}, 0);
    @(posedge clock); #1;
    chk({tag, "_valid_t2"}, {31'd0, bus.out_valid}, 1);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Expected wet output for sample k (1-based) of a continuous reverse run, 8-sample chunks.
  function automatic int rev_exp(input int k);
    int c, j;
    c = (k - 1) / 8;
    j = (k - 1) % 8 + 1;
    return (c == 0) ? 0 : 8 * (c - 1) + 9 - j;
  endfunction

  initial begin
    bus.ready = 1'b0; bus.enable = 1'b0; bus.dry_mix = 1'b0;
    bus.l_audio_in = '0; bus.r_audio_in = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // 1: reset state and bypass
    chk("rst_l", bus.l_audio_out, 0);
    chk("rst_r", bus.r_audio_out, 0);
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_bank", {31'd0, bus.bank}, 0);
    chk("rst_playing", {31'd0, bus.playing}, 0);
    send(18'sd100, -18'sd100, "byp");
    chk("byp_l", bus.l_audio_out, 100);
    chk("byp_r", bus.r_audio_out, -100);
    @(posedge clock); #1;
    chk("byp_pulse", {31'd0, bus.out_valid}, 0);
    chk("byp_hold_l", bus.l_audio_out, 100);

    // 2: ramp 1..24 reversed in chunks of 8
    bus.enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      send(18'(k), 18'(-k), "ramp");
      chk($sformatf("ramp_l%0d", k), bus.l_audio_out, rev_exp(k));
      if (k == 7 || k == 15)
        chk($sformatf("ramp_bank%0d", k), {31'd0, bus.bank}, (k == 7) ? 0 : 1);
      if (k == 8 || k == 16)
        chk($sformatf("ramp_bank%0d", k), {31'd0, bus.bank}, (k == 8) ? 1 : 0);
      if (k == 8) chk("ramp_playing8", {31'd0, bus.playing}, 1);
    end

    // 3: dry/wet mix
    do_reset();
    bus.dry_mix = 1'b0;
    for (int k = 1; k <= 8; k++) send(18'sd2000, -18'sd131072, "mixfill");
    chk("mixfill_l", bus.l_audio_out, 0);
    bus.dry_mix = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(18'sd1000, -18'sd131072, "mix");
      if (k == 1 || k == 8) begin
        chk($sformatf("mix_l%0d", k), bus.l_audio_out, 1500);
        chk($sformatf("mix_r%0d", k), bus.r_audio_out, -131072);
      end
    end

    // 4: drop enable at ptr=5 in PLAY, then refill from ptr 0 bank 0
    bus.dry_mix = 1'b0;
    for (int k = 1; k <= 5; k++) send(18'sd3, 18'sd3, "pre_drop");
    chk("pre_drop_playing", {31'd0, bus.playing}, 1);
    bus.enable = 1'b0;
    send(18'sd77, -18'sd77, "drop");
    chk("drop_l", bus.l_audio_out, 77);
    chk("drop_r", bus.r_audio_out, -77);
    chk("drop_playing", {31'd0, bus.playing}, 0);
    chk("drop_bank", {31'd0, bus.bank}, 0);
    bus.enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      send(18'(10 + k), 18'(k), "refill");
      chk($sformatf("refill_l%0d", k), bus.l_audio_out, (k <= 8) ? 0 : 18);
      if (k == 9) chk("refill_r9", bus.r_audio_out, 8);
      if (k == 7) chk("refill_bank7", {31'd0, bus.bank}, 0);
      if (k == 8) chk("refill_playing8", {31'd0, bus.playing}, 1);
    end

    // 5: reset mid-PLAY with a sample in flight and ready during reset
    do_reset();
    for (int k = 1; k <= 10; k++) send(18'(k), 18'(k), "r5");
    chk("r5_playing", {31'd0, bus.playing}, 1);
    @(posedge clock); #1;
    bus.ready = 1'b1; bus.l_audio_in = 18'sd500;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    bus.ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("r5_valid_c%0d", c), {31'd0, bus.out_valid}, 0);
      chk($sformatf("r5_l_c%0d", c), bus.l_audio_out, 0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    chk("r5_playing_after", {31'd0, bus.playing}, 0);
    chk("r5_bank_after", {31'd0, bus.bank}, 0);
    repeat (3) begin
      @(posedge clock); #1;
      chk("r5_quiet", {31'd0, bus.out_valid}, 0);
    end
    send(18'sd55, -18'sd55, "r5_first");
    chk("r5_first_l", bus.l_audio_out, 0);
    chk("r5_first_playing", {31'd0, bus.playing}, 0);

    // 6: 40 samples at the minimum 3-clock spacing
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      send(18'(k), 18'(-k), "sp");
      chk($sformatf("sp_l%0d", k), bus.l_audio_out, rev_exp(k));
      chk($sformatf("sp_r%0d", k), bus.r_audio_out, -rev_exp(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
